serial_frame_rx: RTL and testbench

- Downstream consumer of the serial shift-register stage. Takes the 1-bit serial stream (`dout` of the `siso` chain) and frames it.
- Detects a start bit, deserializes DATA_W data bits LSB-first, checks an optional parity bit and the stop bit.
- Presents the parallel word with a valid/ack handshake and error/overrun status.
- Bit-rate is one bit per `en` strobe, so it can run at the core clock or slower.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/sipo_shift.sv | 34 +++
 rtl/serial_frame_rx.sv | 108 ++++++++++
 tb/tb_serial_frame_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial framing blocks: receiver FSM states,
// line levels and the parity check used by the receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;
  localparam logic LINE_STOP  = 1'b0;

  // data_xor is the XOR-reduction of the data bits; odd selects odd parity.
  function automatic logic parity_bad(input logic data_xor, input logic parity_bit,
                                      input logic odd);
    return (data_xor ^ parity_bit) != odd;
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out register: shifts right, new bit enters at the MSB,
// so after DATA_W shifts the first bit received sits at bit 0.
module sipo_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              sin,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] q_next;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    if (gi == DATA_W - 1) begin : g_msb
      assign q_next[gi] = sin;
    end else begin : g_lower
      assign q_next[gi] = q_reg[gi+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (shift_en) begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional
// parity bit, stop bit; presents the word with a valid/ack handshake.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ack,
  output logic              parity_err,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  state_t            state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              par_err_reg;
  logic [DATA_W-1:0] shift_q;
  logic              shift_en;

  assign shift_en = en && (state_reg == DATA);

  sipo_shift #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (reset),
    .shift_en (shift_en),
    .sin      (din),
    .q        (shift_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      par_err_reg <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // An ack on an idle interface is ignored; a same-cycle completion below
      // overrides this clear.
      if (dout_ack && dout_valid) begin
        dout_valid <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end

      if (en) begin
        case (state_reg)
          IDLE: begin
            if (din == LINE_START) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
              busy        <= 1'b1;
            end
          end
          DATA: begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
          PARITY: begin
            par_err_reg <= parity_bad(^shift_q, din, ODD);
            state_reg   <= STOP;
          end
          STOP: begin
            // A bad stop bit always returns to IDLE; it never doubles as a start bit.
            if (din == LINE_STOP) begin
              dout       <= shift_q;
              dout_valid <= 1'b1;
              parity_err <= (PARITY_EN != 0) ? par_err_reg : 1'b0;
              overrun    <= dout_valid && !dout_ack;
            end else begin
              frame_err <= 1'b1;
            end
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised bench for serial_frame_rx: frames are generated from a word-level
// model; a monitor compares the DUT's status each time a frame completes.
module tb_serial_frame_rx;

  localparam int DATA_W     = 8;
  localparam int PARITY_EN  = 1;
  localparam int PARITY_ODD = 0;

  logic              clk;
  logic              reset;
  logic              din;
  logic              en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ack;
  logic              parity_err;
  logic              overrun;
  logic              frame_err;
  logic              busy;

  serial_frame_rx #(
    .DATA_W     (DATA_W),
    .PARITY_EN  (PARITY_EN),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ack   (dout_ack),
    .parity_err (parity_err),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic              valid;
    logic              perr;
    logic              ovr;
    logic              ferr;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Word-level model of what the consumer should see.
  logic [DATA_W-1:0] m_word  = '0;
  logic              m_valid = 1'b0;
  logic              m_perr  = 1'b0;
  logic              m_ovr   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic d, input logic e, input logic a);
    din      = d;
    en       = e;
    dout_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic gaps(input int n);
    repeat (n) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  // gap_mode 0: none, 1: three en-low cycles after 2nd data bit and parity bit,
  // 2: random en-low cycles anywhere in the frame.
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic pbit,
                            input logic sbit, input logic ack, input int gap_mode);
    exp_t e;
    logic pe;
    cyc(1'b1, 1'b1, 1'b0);
    if (gap_mode == 2) gaps($urandom_range(0, 2));
    for (int i = 0; i < DATA_W; i++) begin
      cyc(data[i], 1'b1, 1'b0);
      if (gap_mode == 1 && i == 1) gaps(3);
      if (gap_mode == 2 && $urandom_range(0, 3) == 0) gaps($urandom_range(1, 2));
    end
    if (PARITY_EN != 0) begin
      cyc(pbit, 1'b1, 1'b0);
      if (gap_mode == 1) gaps(3);
      if (gap_mode == 2) gaps($urandom_range(0, 1));
    end
    pe = (PARITY_EN != 0) && ((($countones(data) + int'(pbit)) % 2) != PARITY_ODD);
    if (sbit == 1'b0) begin
      m_ovr   = m_valid && !ack;
      m_valid = 1'b1;
      m_word  = data;
      m_perr  = pe;
    end
    e.word  = m_word;
    e.valid = m_valid;
    e.perr  = m_perr;
    e.ovr   = m_ovr;
    e.ferr  = sbit;
    exp_q.push_back(e);
    cyc(sbit, 1'b1, ack);
  endtask

  task automatic do_ack(input string name);
    cyc(1'b0, 1'b1, 1'b1);
    if (m_valid) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_ovr   = 1'b0;
    end
    check({name, "_valid"}, 32'(dout_valid), 32'(m_valid));
    check({name, "_perr"},  32'(parity_err), 32'(m_perr));
    check({name, "_ovr"},   32'(overrun),    32'(m_ovr));
    check({name, "_dout"},  32'(dout),       32'(m_word));
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Monitor: a frame has completed when busy falls while out of reset.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion: got dout=%0h with nothing expected at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          $display("frame done: dout=%0h valid=%0b perr=%0b ovr=%0b ferr=%0b", dout, dout_valid,
                   parity_err, overrun, frame_err);
          check("mon_dout",      32'(dout),       32'(e.word));
          check("mon_valid",     32'(dout_valid), 32'(e.valid));
          check("mon_perr",      32'(parity_err), 32'(e.perr));
          check("mon_ovr",       32'(overrun),    32'(e.ovr));
          check("mon_frame_err", 32'(frame_err),  32'(e.ferr));
        end
      end else if (frame_err) begin
        check("stray_frame_err", 32'(frame_err), 32'(0));
      end
    end
    prev_busy = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic              pb;
    logic              sb;
    logic              ak;

    reset = 1'b0; din = 1'b0; en = 1'b0; dout_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout",  32'(dout),       32'(0));
    check("rst_valid", 32'(dout_valid), 32'(0));
    check("rst_perr",  32'(parity_err), 32'(0));
    check("rst_ovr",   32'(overrun),    32'(0));
    check("rst_ferr",  32'(frame_err),  32'(0));
    check("rst_busy",  32'(busy),       32'(0));
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);

    // Good frame, then parity error.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
    do_ack("t1_ack");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    do_ack("t2_ack");

    // Framing error followed by a good frame.
    send_frame(8'h3C, even_par(8'h3C), 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0);
    check("t3_frame_err_over", 32'(frame_err), 32'(0));
    send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b0, 0);
    do_ack("t3_ack");

    // Overrun without ack, then with ack on the completion cycle.
    send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b0, 0);
    send_frame(8'h81, even_par(8'h81), 1'b0, 1'b0, 0);
    do_ack("t4_ack");
    send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b0, 0);
    send_frame(8'h81, even_par(8'h81), 1'b0, 1'b1, 0);
    do_ack("t4b_ack");

    // en gating.
    send_frame(8'h5A, even_par(8'h5A), 1'b0, 1'b0, 1);
    do_ack("t5_ack");

    // Reset mid-frame with a word pending.
    send_frame(8'hC3, even_par(8'hC3), 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check("t6_dout",  32'(dout),       32'(0));
    check("t6_valid", 32'(dout_valid), 32'(0));
    check("t6_perr",  32'(parity_err), 32'(0));
    check("t6_ovr",   32'(overrun),    32'(0));
    check("t6_busy",  32'(busy),       32'(0));
    m_word = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, even_par(8'h5A), 1'b0, 1'b0, 0);
    do_ack("t6_ack");

    // Randomised frames.
    for (int n = 0; n < 150; n++) begin
      d  = DATA_W'($urandom);
      pb = ($urandom_range(0, 4) == 0) ? ~even_par(d) : even_par(d);
      sb = ($urandom_range(0, 5) == 0);
      ak = !sb && ($urandom_range(0, 3) == 0);
      send_frame(d, pb, sb, ak, ($urandom_range(0, 2) == 0) ? 2 : 0);
      if ($urandom_range(0, 2) == 0) do_ack("rnd_ack");
      repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
